hazard_ctrl: RTL and testbench

//  Control-side producer of the forwarding selects for D/E/M operand muxes, and of the pipeline stall.

---
 rtl/hazard_ctrl_pkg.sv | 43 ++++
 rtl/hazard_ctrl_md_busy_counter.sv | 41 ++++
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared forwarding-select codes, the Tuse "never" encoding and
//                small helpers for the hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Forwarding select codes, shared with the operand muxes
    localparam logic [1:0] c_ODATA      = 2'b00;
    localparam logic [1:0] c_EDATA      = 2'b01;
    localparam logic [1:0] c_MDATA      = 2'b10;
    localparam logic [1:0] c_WDATA      = 2'b11;

    // A source with this Tuse is never read, so it can never stall
    localparam logic [1:0] c_TUSE_NEVER = 2'd3;

    // Register 0 is hard-wired, so a write to it never creates a dependency
    function automatic logic reg_match(input logic [4:0] a3, input logic [4:0] r);
        return (r != 5'd0) && (a3 == r);
    endfunction

    // Tnew one stage later, saturating at zero
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : (t - 2'd1);
    endfunction

    // Forward select from M/W; the younger M result wins over W
    function automatic logic [1:0] sel_mw(input logic [4:0] r,
                                          input logic [4:0] m_a3,
                                          input logic [1:0] m_tnew,
                                          input logic [4:0] w_a3);
        if (reg_match(m_a3, r) && (m_tnew == 2'd0))
            return c_MDATA;
        else if (reg_match(w_a3, r))
            return c_WDATA;
        else
            return c_ODATA;
    endfunction

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_md_busy_counter.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_counter
//  Description : Mult/div busy timer. Loads the operation latency the cycle
//                after a start leaves E, then counts down to idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int C_MAX   = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int C_CNT_W = $clog2(C_MAX + 1);

    localparam logic [C_CNT_W-1:0] c_MULT_LOAD = C_CNT_W'(MULT_CYCLES);
    localparam logic [C_CNT_W-1:0] c_DIV_LOAD  = C_CNT_W'(DIV_CYCLES);
    localparam logic [C_CNT_W-1:0] c_ONE       = C_CNT_W'(1);

    logic [C_CNT_W-1:0] r_cnt;

    // Load on start, otherwise count down to zero; reset abandons any count
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (start)
            r_cnt <= is_div ? c_DIV_LOAD : c_MULT_LOAD;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - c_ONE;
    end

    assign busy = (r_cnt != '0);

endmodule : md_busy_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Stall and forwarding-select generator. Keeps shadow copies of
//                the E/M/W destination registers and Tnew, and a mult/div busy
//                timer. Stall freezes PC and F/D and bubbles D/E.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_A3,
    input  logic [1:0] D_Tnew,
    input  logic       D_md_op,
    input  logic       D_md_start,
    input  logic       D_md_is_div,
    output logic       stall,
    output logic [1:0] s_D_rs_data,
    output logic [1:0] s_D_rt_data,
    output logic [1:0] s_E_rs_data,
    output logic [1:0] s_E_rt_data,
    output logic [1:0] s_M_rt_data,
    output logic       md_busy
);

    // Shadow state of the in-flight stages
    logic [4:0] r_e_rs;
    logic [4:0] r_e_rt;
    logic [4:0] r_e_a3;
    logic [1:0] r_e_tnew;
    logic       r_e_md_start;
    logic       r_e_is_div;
    logic [4:0] r_m_rt;
    logic [4:0] r_m_a3;
    logic [1:0] r_m_tnew;
    logic [4:0] r_w_a3;

    logic       w_stall_rs;
    logic       w_stall_rt;
    logic       w_stall_md;

    // Mult/div busy timer, started when the op leaves E
    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .start  (r_e_md_start),
        .is_div (r_e_is_div),
        .busy   (md_busy)
    );

    // Advance the shadow pipeline; a stall injects an all-zero bubble into E
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e_rs       <= 5'd0;
            r_e_rt       <= 5'd0;
            r_e_a3       <= 5'd0;
            r_e_tnew     <= 2'd0;
            r_e_md_start <= 1'b0;
            r_e_is_div   <= 1'b0;
            r_m_rt       <= 5'd0;
            r_m_a3       <= 5'd0;
            r_m_tnew     <= 2'd0;
            r_w_a3       <= 5'd0;
        end else begin
            if (stall) begin
                r_e_rs       <= 5'd0;
                r_e_rt       <= 5'd0;
                r_e_a3       <= 5'd0;
                r_e_tnew     <= 2'd0;
                r_e_md_start <= 1'b0;
                r_e_is_div   <= 1'b0;
            end else begin
                r_e_rs       <= D_rs;
                r_e_rt       <= D_rt;
                r_e_a3       <= D_A3;
                r_e_tnew     <= D_Tnew;
                r_e_md_start <= D_md_start;
                r_e_is_div   <= D_md_start & D_md_is_div;
            end
            r_m_rt   <= r_e_rt;
            r_m_a3   <= r_e_a3;
            r_m_tnew <= tnew_dec(r_e_tnew);
            r_w_a3   <= r_m_a3;
        end
    end

    // Stall when a producer is not ready by the time D needs the value; the
    // D muxes have no E path, so any E match with Tuse 0 must also wait
    always_comb begin
        w_stall_rs = 1'b0;
        w_stall_rt = 1'b0;
        w_stall_md = 1'b0;

        if (reg_match(r_e_a3, D_rs) &&
            ((r_e_tnew > D_Tuse_rs) || (D_Tuse_rs == 2'd0)))
            w_stall_rs = 1'b1;
        if (reg_match(r_m_a3, D_rs) && (r_m_tnew > D_Tuse_rs))
            w_stall_rs = 1'b1;

        if (reg_match(r_e_a3, D_rt) &&
            ((r_e_tnew > D_Tuse_rt) || (D_Tuse_rt == 2'd0)))
            w_stall_rt = 1'b1;
        if (reg_match(r_m_a3, D_rt) && (r_m_tnew > D_Tuse_rt))
            w_stall_rt = 1'b1;

        w_stall_md = D_md_op && (md_busy || r_e_md_start);

        stall = w_stall_rs | w_stall_rt | w_stall_md;
    end

    // Forwarding selects from current shadow state, no added latency
    always_comb begin
        s_D_rs_data = sel_mw(D_rs,   r_m_a3, r_m_tnew, r_w_a3);
        s_D_rt_data = sel_mw(D_rt,   r_m_a3, r_m_tnew, r_w_a3);
        s_E_rs_data = sel_mw(r_e_rs, r_m_a3, r_m_tnew, r_w_a3);
        s_E_rt_data = sel_mw(r_e_rt, r_m_a3, r_m_tnew, r_w_a3);
        s_M_rt_data = reg_match(r_w_a3, r_m_rt) ? c_WDATA : c_ODATA;
    end

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed self-checking bench for hazard_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam logic [1:0] ODATA = 2'b00;
    localparam logic [1:0] MDATA = 2'b10;
    localparam logic [1:0] WDATA = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
    logic       D_md_op, D_md_start, D_md_is_div;
    logic       stall, md_busy;
    logic [1:0] s_D_rs_data, s_D_rt_data, s_E_rs_data, s_E_rt_data, s_M_rt_data;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .D_rs        (D_rs),
        .D_rt        (D_rt),
        .D_Tuse_rs   (D_Tuse_rs),
        .D_Tuse_rt   (D_Tuse_rt),
        .D_A3        (D_A3),
        .D_Tnew      (D_Tnew),
        .D_md_op     (D_md_op),
        .D_md_start  (D_md_start),
        .D_md_is_div (D_md_is_div),
        .stall       (stall),
        .s_D_rs_data (s_D_rs_data),
        .s_D_rt_data (s_D_rt_data),
        .s_E_rs_data (s_E_rs_data),
        .s_E_rt_data (s_E_rt_data),
        .s_M_rt_data (s_M_rt_data),
        .md_busy     (md_busy)
    );

    always #5 clk = ~clk;

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tuse_rs, input logic [1:0] tuse_rt,
                         input logic [4:0] a3, input logic [1:0] tnew,
                         input logic md_op, input logic md_start, input logic is_div);
        D_rs = rs; D_rt = rt; D_Tuse_rs = tuse_rs; D_Tuse_rt = tuse_rt;
        D_A3 = a3; D_Tnew = tnew;
        D_md_op = md_op; D_md_start = md_start; D_md_is_div = is_div;
    endtask

    task automatic set_nop();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        set_nop();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        set_nop();
        reset = 1'b1;
        #3;
        obs = {stall, md_busy, s_D_rs_data, s_D_rt_data, s_E_rs_data, s_E_rt_data, s_M_rt_data};
        n_tests++;
        if (obs !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_initial: got %b expected %b", obs, 11'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);   // div
        tick();
        set_nop();
        repeat (4) tick();                                              // count now 7
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0);   // mflo
        #1;
        n_tests++;
        if ({stall, md_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_pre_busy: got stall,busy=%b expected 11", {stall, md_busy});
        end
        reset = 1'b1;
        #1;
        obs = {stall, md_busy, s_D_rs_data, s_D_rt_data, s_E_rs_data, s_E_rt_data, s_M_rt_data};
        n_tests++;
        if (obs !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected %b", obs, 11'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        n_tests++;
        if ({stall, md_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_abandon: got stall,busy=%b expected 00", {stall, md_busy});
        end
        set_nop();
    endtask

    task automatic test_load_use();
        int n;
        flush();
        set_d(5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);  // lw $8
        tick();
        set_d(5'd8, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);   // beq $8
        #1;
        n = 0;
        while (stall === 1'b1 && n < 20) begin
            n++;
            tick();
            #1;
        end
        n_tests++;
        if (n != 2) begin
            n_fail++;
            $display("FAIL load_use_stall_cycles: got %0d expected 2", n);
        end
        n_tests++;
        if (s_D_rs_data !== WDATA || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_fwd: got sel=%b stall=%b expected sel=%b stall=0",
                     s_D_rs_data, stall, WDATA);
        end
    endtask

    task automatic test_alu_fwd();
        flush();
        set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);   // addu $9
        tick();
        set_d(5'd9, 5'd9, 2'd1, 2'd1, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);  // addu $10,$9,$9
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_no_stall: got %b expected 0", stall);
        end
        tick();
        set_nop();
        #1;
        n_tests++;
        if ({s_E_rs_data, s_E_rt_data} !== {MDATA, MDATA}) begin
            n_fail++;
            $display("FAIL alu_e_fwd: got %b expected %b", {s_E_rs_data, s_E_rt_data}, {MDATA, MDATA});
        end
    endtask

    task automatic test_m_over_w();
        flush();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);   // ori $5 (older)
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);   // ori $5 (younger)
        tick();
        set_nop();
        tick();
        set_d(5'd5, 5'd5, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);   // beq $5,$5
        #1;
        n_tests++;
        if ({stall, s_D_rs_data, s_D_rt_data} !== {1'b0, MDATA, MDATA}) begin
            n_fail++;
            $display("FAIL d_m_over_w: got %b expected %b",
                     {stall, s_D_rs_data, s_D_rt_data}, {1'b0, MDATA, MDATA});
        end
        tick();
        set_nop();
        #1;
        n_tests++;
        if ({s_E_rs_data, s_E_rt_data} !== {WDATA, WDATA}) begin
            n_fail++;
            $display("FAIL e_w_fwd: got %b expected %b", {s_E_rs_data, s_E_rt_data}, {WDATA, WDATA});
        end
        flush();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);   // ori $7
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);   // ori $7
        tick();
        set_d(5'd7, 5'd3, 2'd1, 2'd1, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);   // addu $4,$7,$3
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL e_reader_no_stall: got %b expected 0", stall);
        end
        tick();
        set_nop();
        #1;
        n_tests++;
        if ({s_E_rs_data, s_E_rt_data} !== {MDATA, ODATA}) begin
            n_fail++;
            $display("FAIL e_m_over_w: got %b expected %b", {s_E_rs_data, s_E_rt_data}, {MDATA, ODATA});
        end
    endtask

    task automatic test_store_data();
        flush();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);   // ori $6
        tick();
        set_d(5'd29, 5'd6, 2'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);  // sw $6
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL store_no_stall: got %b expected 0", stall);
        end
        tick();
        set_nop();
        #1;
        n_tests++;
        if (s_E_rt_data !== MDATA) begin
            n_fail++;
            $display("FAIL store_e_rt: got %b expected %b", s_E_rt_data, MDATA);
        end
        tick();
        #1;
        n_tests++;
        if (s_M_rt_data !== WDATA) begin
            n_fail++;
            $display("FAIL store_m_rt: got %b expected %b", s_M_rt_data, WDATA);
        end
    endtask

    task automatic test_zero_reg();
        logic [10:0] obs;
        flush();
        for (int i = 0; i < 4; i++) begin
            set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
            #1;
            obs = {stall, md_busy, s_D_rs_data, s_D_rt_data, s_E_rs_data, s_E_rt_data, s_M_rt_data};
            n_tests++;
            if (obs !== 11'd0) begin
                n_fail++;
                $display("FAIL zero_reg_cycle%0d: got %b expected %b", i, obs, 11'd0);
            end
            tick();
        end
    endtask

    task automatic test_md();
        int n;
        flush();
        set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);   // div
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 1'b1, 1'b0, 1'b0);   // mflo
        #1;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            tick();
            #1;
        end
        n_tests++;
        if (n != 11) begin
            n_fail++;
            $display("FAIL div_stall_cycles: got %0d expected 11", n);
        end
        n_tests++;
        if (md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL div_busy_after: got %b expected 0", md_busy);
        end
        set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);   // mult
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 1'b1, 1'b0, 1'b0);   // mflo
        #1;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            tick();
            #1;
        end
        n_tests++;
        if (n != 6) begin
            n_fail++;
            $display("FAIL mult_stall_cycles: got %0d expected 6", n);
        end
        n_tests++;
        if (md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_busy_after: got %b expected 0", md_busy);
        end
        set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);   // mult
        tick();
        set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd11, 2'd1, 1'b0, 1'b0, 1'b0);  // addu, not a md op
        tick();
        #1;
        n_tests++;
        if ({stall, md_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL non_md_while_busy: got stall,busy=%b expected 01", {stall, md_busy});
        end
        set_nop();
    endtask

    initial begin
        set_nop();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_alu_fwd();
        test_m_over_w();
        test_store_data();
        test_zero_reg();
        test_md();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
